button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 138 +++++++++++++
 tb/tb_button_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: synchronize, debounce, rising-edge
// pulse, with optional auto-repeat on the next-LED channel.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clk,
   input  logic async_nreset,
   input  logic btn_next,
   input  logic btn_mode,
   output logic next_led_re,
   output logic change_mode_re,
   output logic next_level,
   output logic mode_level
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } state_t;

   // Index 0 is the next channel, index 1 the mode channel.
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    lvl_q, lvl_d;
   logic [DW-1:0] dcnt_q [2];
   logic [DW-1:0] dcnt_d [2];
   logic [1:0]    rise;

   state_t        state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          next_re_q, next_re_d;
   logic          mode_re_q, mode_re_d;

   always_comb begin
      sync1_d = {btn_mode, btn_next};
      sync2_d = sync1_q;
      for (int ch = 0; ch < 2; ch++) begin
         lvl_d[ch]  = lvl_q[ch];
         dcnt_d[ch] = '0;
         if (sync2_q[ch] != lvl_q[ch]) begin
            if (dcnt_q[ch] == DB_MAX) begin
               lvl_d[ch] = ~lvl_q[ch];
            end else begin
               dcnt_d[ch] = dcnt_q[ch] + 1'b1;
            end
         end
         rise[ch] = lvl_d[ch] & ~lvl_q[ch];
      end
   end

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      next_re_d = 1'b0;
      mode_re_d = rise[1];
      // A released button aborts any pending repeat in the same edge.
      if (!lvl_d[0]) begin
         state_d = ST_IDLE;
         rcnt_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rise[0]) begin
                  next_re_d = 1'b1;
                  rcnt_d    = '0;
                  if (REPEAT_EN != 0) begin
                     state_d = ST_DELAY;
                  end
               end
            end
            ST_DELAY: begin
               if (rcnt_q == RD_LAST) begin
                  next_re_d = 1'b1;
                  rcnt_d    = '0;
                  state_d   = ST_REPEAT;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (rcnt_q == RP_LAST) begin
                  next_re_d = 1'b1;
                  rcnt_d    = '0;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         lvl_q     <= '0;
         dcnt_q[0] <= '0;
         dcnt_q[1] <= '0;
         state_q   <= ST_IDLE;
         rcnt_q    <= '0;
         next_re_q <= 1'b0;
         mode_re_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         lvl_q     <= lvl_d;
         dcnt_q[0] <= dcnt_d[0];
         dcnt_q[1] <= dcnt_d[1];
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         next_re_q <= next_re_d;
         mode_re_q <= mode_re_d;
      end
   end

   assign next_led_re    = next_re_q;
   assign change_mode_re = mode_re_q;
   assign next_level     = lvl_q[0];
   assign mode_level     = lvl_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/repeat
// parameters; one instance with auto-repeat, one without.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic rst_n;
   logic bn, bm;
   logic a_nre, a_mre, a_nl, a_ml;
   logic b_nre, b_mre, b_nl, b_ml;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut_a (
      .clk(clk), .async_nreset(rst_n),
      .btn_next(bn), .btn_mode(bm),
      .next_led_re(a_nre), .change_mode_re(a_mre),
      .next_level(a_nl), .mode_level(a_ml)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut_b (
      .clk(clk), .async_nreset(rst_n),
      .btn_next(bn), .btn_mode(bm),
      .next_led_re(b_nre), .change_mode_re(b_mre),
      .next_level(b_nl), .mode_level(b_ml)
   );

   typedef struct {
      logic bn;
      logic bm;
      logic nre;
      logic mre;
      logic nl;
      logic ml;
   } vec_t;

   vec_t tab [16];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bn = 1'b0;
      bm = 1'b0;
      repeat (n) tick();
   endtask

   logic [63:0] m_a, m_b, e_a, e_b;
   int          cnt, at, stray;

   initial begin
      // Both buttons pressed before edge 0, released before edge 8.
      tab[0]  = '{1, 1, 0, 0, 0, 0};
      tab[1]  = '{1, 1, 0, 0, 0, 0};
      tab[2]  = '{1, 1, 0, 0, 0, 0};
      tab[3]  = '{1, 1, 0, 0, 0, 0};
      tab[4]  = '{1, 1, 0, 0, 0, 0};
      tab[5]  = '{1, 1, 0, 0, 0, 0};
      tab[6]  = '{1, 1, 1, 1, 1, 1};
      tab[7]  = '{1, 1, 0, 0, 1, 1};
      tab[8]  = '{0, 0, 0, 0, 1, 1};
      tab[9]  = '{0, 0, 0, 0, 1, 1};
      tab[10] = '{0, 0, 0, 0, 1, 1};
      tab[11] = '{0, 0, 0, 0, 1, 1};
      tab[12] = '{0, 0, 0, 0, 1, 1};
      tab[13] = '{0, 0, 0, 0, 1, 1};
      tab[14] = '{0, 0, 0, 0, 0, 0};
      tab[15] = '{0, 0, 0, 0, 0, 0};

      rst_n = 1'b0;
      bn    = 1'b0;
      bm    = 1'b0;
      tick();
      check("rst_a_nre", 64'(a_nre), 64'd0);
      check("rst_a_mre", 64'(a_mre), 64'd0);
      check("rst_a_nl", 64'(a_nl), 64'd0);
      check("rst_a_ml", 64'(a_ml), 64'd0);
      check("rst_b_nre", 64'(b_nre), 64'd0);
      check("rst_b_ml", 64'(b_ml), 64'd0);
      rst_n = 1'b1;
      idle(3);

      for (int i = 0; i < 16; i++) begin
         bn = tab[i].bn;
         bm = tab[i].bm;
         tick();
         check($sformatf("tab%0d_nre", i), 64'(a_nre), 64'(tab[i].nre));
         check($sformatf("tab%0d_mre", i), 64'(a_mre), 64'(tab[i].mre));
         check($sformatf("tab%0d_nl", i), 64'(a_nl), 64'(tab[i].nl));
         check($sformatf("tab%0d_ml", i), 64'(a_ml), 64'(tab[i].ml));
      end
      idle(4);

      // Bounce 1,0,1,0 then hold: final rise is at edge 4.
      cnt = 0;
      at  = -1;
      for (int k = 0; k < 15; k++) begin
         bn = (k < 4) ? ((k % 2) == 0) : 1'b1;
         tick();
         if (a_nre) begin
            cnt++;
            at = k;
         end
      end
      check("bounce_count", 64'(cnt), 64'd1);
      check("bounce_cycle", 64'(at), 64'd10);
      idle(20);
      check("bounce_rel_lvl", 64'(a_nl), 64'd0);

      // Auto-repeat with button held for 30 cycles.
      m_a   = '0;
      m_b   = '0;
      stray = 0;
      for (int k = 0; k < 50; k++) begin
         bn = (k < 30);
         tick();
         m_a[k] = a_nre;
         m_b[k] = b_nre;
         if (k >= 30 && !a_nl && a_nre) stray++;
      end
      e_a = '0;
      e_a[6]  = 1'b1;
      e_a[16] = 1'b1;
      e_a[19] = 1'b1;
      e_a[22] = 1'b1;
      e_a[25] = 1'b1;
      e_a[28] = 1'b1;
      e_b = '0;
      e_b[6] = 1'b1;
      check("rep_pulses", {34'd0, m_a[29:0]}, {34'd0, e_a[29:0]});
      check("rep_after_rel", 64'(stray), 64'd0);
      check("rep_tail", {14'd0, m_a[49:36]}, 64'd0);
      check("norep_pulses", m_b, e_b);
      check("rep_lvl_end", 64'(a_nl), 64'd0);
      check("mode_quiet", 64'(a_ml), 64'd0);
      idle(4);

      // Reset at cycle 4 of a press, button still held afterwards.
      bn = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_re", 64'(a_nre), 64'd0);
      tick();
      check("midrst_hold_re", 64'(a_nre), 64'd0);
      rst_n = 1'b1;
      m_a = '0;
      for (int j = 0; j < 10; j++) begin
         tick();
         m_a[j] = a_nre;
      end
      e_a = '0;
      e_a[6] = 1'b1;
      check("midrst_pulse", m_a, e_a);
      check("midrst_lvl", 64'(a_nl), 64'd1);

      // Asynchronous reset mid-repeat clears everything without an edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_nl", 64'(a_nl), 64'd0);
      check("async_nre", 64'(a_nre), 64'd0);
      bn = 1'b0;
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int j = 0; j < 25; j++) begin
         tick();
         if (a_nre || a_nl) cnt++;
      end
      check("post_rst_quiet", 64'(cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
